load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage. It sits directly downstream of the ALU control unit in the single cycle processor.
- Consumes the ALU result (effective address), rs2 store data, MemRead/MemWrite, and the 3-bit byte_select code (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- Drives a word-addressed memory bus with a valid/ready handshake and byte enables. Returns sign- or zero-extended load data to the writeback mux.
- Stalls the core (PC/register-file write freeze) until the access completes.

Parameters:
- ADDR_WIDTH, 32, width of the address and bus_addr ports. Bits [1:0] of bus_addr are always 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  MemRead|MemWrite of the current instruction.
- req_write  input  1  1 = store, 0 = load.
- byte_select  input  3  access size/sign code from the ALU control unit.
- addr  input  ADDR_WIDTH  effective byte address (ALU result).
- wdata  input  32  store data, right-aligned.
- stall  output  1  freeze core while an access is pending.
- done  output  1  one-cycle pulse: access complete.
- load_data  output  32  extended load result.
- misalign_fault  output  1  pulses with done on a rejected misaligned access.
- bus_valid  output  1  bus request.
- bus_ready  input  1  memory accepts / returns data this cycle.
- bus_we  output  1  bus write.
- bus_addr  output  ADDR_WIDTH  word-aligned bus address.
- bus_be  output  4  byte enables, bit i = byte lane i.
- bus_wdata  output  32  lane-aligned write data.
- bus_rdata  input  32  read data, valid when bus_valid & bus_ready.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0, including load_data. bus_valid drops immediately, mid-transaction included.
- Request capture:
  - Request fields are captured in IDLE on req_valid.
  - off = addr[1:0].
  - mask = 0001 (B/BU), 0011 (H/HU), 1111 (W).
  - Codes 011/110/111 are treated as W.
  - split = (H/HU and off==3) or (W and off!=0).
- States:
  - IDLE -> ACC0 on req_valid and not split. Also -> ACC0 on split when MISALIGN_SPLIT_EN is defined.
  - ACC0 -> ACC1 on bus_valid & bus_ready when split. Otherwise -> DONE.
  - ACC1 -> DONE on bus_valid & bus_ready.
  - DONE -> IDLE unconditionally. req_valid is ignored in DONE.
- stall = (IDLE & req_valid) | ACC0 | ACC1. Combinational, so stall is high in the request cycle itself. stall is 0 in DONE, so the core advances that cycle.
- ACC0 bus outputs:
  - bus_valid = 1.
  - bus_addr = {addr[W-1:2], 2'b00}.
  - bus_be = (mask << off)[3:0].
  - bus_wdata = (wdata << 8*off)[31:0].
  - bus_we = req_write.
- ACC1 bus outputs:
  - bus_addr = ACC0 address + 4.
  - bus_be = mask >> (4-off).
  - bus_wdata = wdata >> 8*(4-off).
- All bus outputs are held stable while bus_valid & !bus_ready. They are 0 outside ACC0/ACC1.
- bus_ready while bus_valid = 0 is ignored.
- Read data:
  - bus_rdata is captured into rd0 at ACC0 completion and rd1 at ACC1 completion. rd1 = 0 if not split.
  - raw = ({rd1, rd0} >> 8*off)[31:0].
  - Extension: B sign-extends bit 7, BU zero-extends 8 bits; H sign-extends bit 15, HU zero-extends 16 bits; W passes raw unchanged.
- load_data is registered. It updates on entry to DONE for loads only, and holds until the next load completes. Stores leave it unchanged.
- done = 1 exactly in DONE. Latency = bus wait cycles + 2 (aligned) or + 3 (split).

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined: a split access performs two bus transactions (ACC0, ACC1) and merges the read data as above. misalign_fault stays 0.
- Undefined: a split request goes IDLE -> DONE with no bus activity. misalign_fault = 1 for that DONE cycle, load_data is unchanged, and stall is high for the request cycle only.

Test Plan:
1. LW addr 0x100; bus_ready after 2 wait cycles; rdata 0xDEADBEEF -> bus_addr 0x100, be 1111; stall high 4 cycles; done pulse; load_data 0xDEADBEEF.
2. LB addr 0x103, rdata 0x80000000 -> be 1000, load_data 0xFFFFFF80. Same access as LBU -> 0x00000080.
3. SH addr 0x102, wdata 0x1234ABCD -> bus_we 1, be 1100, bus_wdata 0xABCD0000; load_data unchanged.
4. MISALIGN_SPLIT_EN defined: LW addr 0x101, rdata 0x44332211 then 0x88776655 -> transactions 0x100/be 1110 and 0x104/be 0001; load_data 0x55443322.
5. MISALIGN_SPLIT_EN undefined: same LW 0x101 -> bus_valid never asserts; misalign_fault and done pulse together one cycle after the request.
6. rst_n low during ACC0 wait -> bus_valid, stall, done drop at once; after release, LW addr 0x200 completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus with valid/ready handshake and per-lane byte enables.
// The load/store unit is the master and data memory is the slave.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: drives the data-memory bus, stalls the core, returns extended load data.
// Build option MISALIGN_SPLIT_EN: misaligned accesses become two bus transactions instead of a fault.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            byte_select,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  misalign_fault,
  load_store_unit_if.master     bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t                state;
  size_t                 req_size;
  size_t                 size_q;
  logic [1:0]            req_off;
  logic [3:0]            req_mask;
  logic                  req_split;
  logic                  reject;
  logic [ADDR_WIDTH-1:0] acc0_addr;
  logic [3:0]            acc0_be;
  logic [31:0]           acc0_wdata;

  logic [ADDR_WIDTH-1:0] word_addr_q;
  logic [1:0]            off_q;
  logic [3:0]            mask_q;
  logic                  uns_q;
  logic                  write_q;
  logic                  split_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd0;

  logic [1:0]            hi_shift;
  logic [ADDR_WIDTH-1:0] acc1_addr;
  logic [3:0]            acc1_be;
  logic [31:0]           acc1_wdata;
  logic [63:0]           rd_pair;
  logic [31:0]           raw;
  logic [31:0]           ext_data;

  // Decode the incoming request; unused codes 011/110/111 fall through to word size.
  always_comb begin
    req_off = addr[1:0];
    case (byte_select[1:0])
      2'b00:   req_size = SZ_B;
      2'b01:   req_size = SZ_H;
      default: req_size = SZ_W;
    endcase
    case (req_size)
      SZ_B:    req_mask = 4'b0001;
      SZ_H:    req_mask = 4'b0011;
      default: req_mask = 4'b1111;
    endcase
    req_split  = ((req_size == SZ_H) && (req_off == 2'd3)) ||
                 ((req_size == SZ_W) && (req_off != 2'd0));
    acc0_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
    acc0_be    = req_mask << req_off;
    acc0_wdata = wdata << {req_off, 3'b000};
  end

`ifdef MISALIGN_SPLIT_EN
  assign reject = 1'b0;
`else
  assign reject = req_split;
`endif

  // Second beat carries the bytes that spilled past the first word: shift by 4-off lanes.
  always_comb begin
    hi_shift   = 2'd0 - off_q;
    acc1_addr  = word_addr_q + ADDR_WIDTH'(4);
    acc1_be    = mask_q >> hi_shift;
    acc1_wdata = wdata_q >> {hi_shift, 3'b000};
  end

  always_comb begin
    rd_pair = (state == ACC1) ? {bus.bus_rdata, rd0} : {32'd0, bus.bus_rdata};
    raw     = 32'(rd_pair >> {off_q, 3'b000});
    case (size_q)
      SZ_B:    ext_data = uns_q ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    ext_data = uns_q ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext_data = raw;
    endcase
  end

  assign stall = ((state == IDLE) && req_valid) || (state == ACC0) || (state == ACC1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      done           <= 1'b0;
      misalign_fault <= 1'b0;
      load_data      <= 32'd0;
      bus.bus_valid  <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_be     <= 4'd0;
      bus.bus_wdata  <= 32'd0;
      word_addr_q    <= '0;
      off_q          <= 2'd0;
      mask_q         <= 4'd0;
      size_q         <= SZ_B;
      uns_q          <= 1'b0;
      write_q        <= 1'b0;
      split_q        <= 1'b0;
      wdata_q        <= 32'd0;
      rd0            <= 32'd0;
    end else begin
      done           <= 1'b0;
      misalign_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            word_addr_q <= acc0_addr;
            off_q       <= req_off;
            mask_q      <= req_mask;
            size_q      <= req_size;
            uns_q       <= byte_select[2];
            write_q     <= req_write;
            split_q     <= req_split;
            wdata_q     <= wdata;
            if (reject) begin
              state          <= DONE;
              done           <= 1'b1;
              misalign_fault <= 1'b1;
            end else begin
              state         <= ACC0;
              bus.bus_valid <= 1'b1;
              bus.bus_we    <= req_write;
              bus.bus_addr  <= acc0_addr;
              bus.bus_be    <= acc0_be;
              bus.bus_wdata <= acc0_wdata;
            end
          end
        end
        ACC0: begin
          if (bus.bus_ready) begin
            rd0 <= bus.bus_rdata;
            if (split_q) begin
              state         <= ACC1;
              bus.bus_addr  <= acc1_addr;
              bus.bus_be    <= acc1_be;
              bus.bus_wdata <= acc1_wdata;
            end else begin
              state         <= DONE;
              done          <= 1'b1;
              bus.bus_valid <= 1'b0;
              bus.bus_we    <= 1'b0;
              bus.bus_addr  <= '0;
              bus.bus_be    <= 4'd0;
              bus.bus_wdata <= 32'd0;
              if (!write_q) load_data <= ext_data;
            end
          end
        end
        ACC1: begin
          if (bus.bus_ready) begin
            state         <= DONE;
            done          <= 1'b1;
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
            if (!write_q) load_data <= ext_data;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-lane memory model predicts every bus beat, stall/done and load result.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int AW = 32;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  byte_select;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misalign_fault;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .byte_select    (byte_select),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .done           (done),
    .load_data      (load_data),
    .misalign_fault (misalign_fault),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        exp_stall, exp_done, exp_fault, exp_valid, exp_we;
  logic [31:0] exp_addr, exp_wd, exp_ld;
  logic [3:0]  exp_be;

  int          stall_cycles, valid_cycles, fault_done_cycles;
  logic [31:0] seen_addr[$];
  logic [3:0]  seen_be[$];
  logic [31:0] seen_wdata[$];
  logic        seen_we[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge the DUT outputs are held against the model's expectation for this cycle.
  always @(negedge clk) begin
    checkOutput("stall", {31'd0, stall}, {31'd0, exp_stall});
    checkOutput("done", {31'd0, done}, {31'd0, exp_done});
    checkOutput("misalign_fault", {31'd0, misalign_fault}, {31'd0, exp_fault});
    checkOutput("load_data", load_data, exp_ld);
    checkOutput("bus_valid", {31'd0, bus.bus_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      checkOutput("bus_addr", bus.bus_addr, exp_addr);
      checkOutput("bus_be", {28'd0, bus.bus_be}, {28'd0, exp_be});
      checkOutput("bus_we", {31'd0, bus.bus_we}, {31'd0, exp_we});
      checkOutput("bus_wdata", bus.bus_wdata, exp_wd);
    end else begin
      checkOutput("idle_bus_addr", bus.bus_addr, 32'd0);
      checkOutput("idle_bus_be", {28'd0, bus.bus_be}, 32'd0);
      checkOutput("idle_bus_we", {31'd0, bus.bus_we}, 32'd0);
      checkOutput("idle_bus_wdata", bus.bus_wdata, 32'd0);
    end
    if (stall) stall_cycles++;
    if (bus.bus_valid) valid_cycles++;
    if (done && misalign_fault) fault_done_cycles++;
    if (bus.bus_valid && bus.bus_ready) begin
      seen_addr.push_back(bus.bus_addr);
      seen_be.push_back(bus.bus_be);
      seen_wdata.push_back(bus.bus_wdata);
      seen_we.push_back(bus.bus_we);
    end
  end

  task automatic clearObservations();
    stall_cycles      = 0;
    valid_cycles      = 0;
    fault_done_cycles = 0;
    seen_addr.delete();
    seen_be.delete();
    seen_wdata.delete();
    seen_we.delete();
  endtask

  // Each access byte k lives at byte address a+k; that picks its word beat and lane.
  task automatic applyStimulus(input logic wr, input logic [2:0] bsel, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rdw0,
                               input logic [31:0] rdw1, input int waits);
    int          n, off, ntx, pos, w, lane;
    bit          issplit, rej, uns;
    logic [31:0] txn_addr [2];
    logic [3:0]  txn_be   [2];
    logic [31:0] txn_wd   [2];
    logic [31:0] txn_rd   [2];
    logic [31:0] val;
    case (bsel[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      default: n = 4;
    endcase
    uns     = bsel[2] && (n < 4);
    off     = int'(a[1:0]);
    issplit = (off + n) > 4;
    rej     = issplit && !SPLIT_EN;
    ntx     = rej ? 0 : (issplit ? 2 : 1);
    txn_addr[0] = {a[31:2], 2'b00};
    txn_addr[1] = txn_addr[0] + 32'd4;
    txn_rd[0] = rdw0;
    txn_rd[1] = rdw1;
    txn_be[0] = 4'd0;
    txn_be[1] = 4'd0;
    txn_wd[0] = 32'd0;
    txn_wd[1] = 32'd0;
    val = 32'd0;
    for (int k = 0; k < n; k++) begin
      pos  = off + k;
      w    = pos / 4;
      lane = pos % 4;
      txn_be[w][lane] = 1'b1;
      txn_wd[w][lane*8 +: 8] = wd[k*8 +: 8];
      val[k*8 +: 8] = txn_rd[w][lane*8 +: 8];
    end
    if ((n < 4) && !uns && val[8*n-1])
      for (int k = n; k < 4; k++) val[k*8 +: 8] = 8'hFF;

    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; byte_select = bsel; addr = a; wdata = wd;
    bus.bus_ready = 1'b1;
    bus.bus_rdata = 32'hFFFF_FFFF;
    exp_stall = 1'b1; exp_done = 1'b0; exp_fault = 1'b0; exp_valid = 1'b0;

    for (int t = 0; t < ntx; t++) begin
      for (int c = 0; c <= waits; c++) begin
        @(posedge clk); #1;
        req_valid = 1'b0; byte_select = 3'b000; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
        bus.bus_ready = (c == waits);
        bus.bus_rdata = (c == waits) ? txn_rd[t] : 32'h0BAD_0BAD;
        exp_stall = 1'b1; exp_valid = 1'b1;
        exp_addr = txn_addr[t]; exp_be = txn_be[t]; exp_we = wr; exp_wd = txn_wd[t];
      end
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; byte_select = 3'b010; addr = 32'h300;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = 32'd0;
    exp_stall = 1'b0; exp_done = 1'b1; exp_fault = rej; exp_valid = 1'b0;
    if (!wr && !rej) exp_ld = val;

    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_done = 1'b0; exp_fault = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; byte_select = 3'b000; addr = 32'd0; wdata = 32'd0;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = 32'd0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_fault = 1'b0; exp_valid = 1'b0; exp_we = 1'b0;
    exp_addr = 32'd0; exp_wd = 32'd0; exp_ld = 32'd0; exp_be = 4'd0;
    clearObservations();
    @(negedge clk);
    checkOutput("reset_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] LW 0x100 with two wait cycles");
    clearObservations();
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h0, 2);
    checkOutput("t1_load_data", load_data, 32'hDEAD_BEEF);
    checkOutput("t1_stall_cycles", 32'(stall_cycles), 32'd4);
    checkOutput("t1_bus_addr", seen_addr[0], 32'h100);
    checkOutput("t1_bus_be", {28'd0, seen_be[0]}, 32'hF);

    $display("[TB] LB / LBU 0x103");
    clearObservations();
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 0);
    checkOutput("t2_lb_load_data", load_data, 32'hFFFF_FF80);
    checkOutput("t2_lb_be", {28'd0, seen_be[0]}, 32'h8);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 1);
    checkOutput("t2_lbu_load_data", load_data, 32'h0000_0080);

    $display("[TB] SH 0x102");
    clearObservations();
    applyStimulus(1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 32'h0, 1);
    checkOutput("t3_bus_we", {31'd0, seen_we[0]}, 32'd1);
    checkOutput("t3_bus_be", {28'd0, seen_be[0]}, 32'hC);
    checkOutput("t3_bus_wdata", seen_wdata[0], 32'hABCD_0000);
    checkOutput("t3_load_data_held", load_data, 32'h0000_0080);

    $display("[TB] assorted aligned sizes and codes");
    applyStimulus(1'b0, 3'b001, 32'h101, 32'h0, 32'h00F0_0100, 32'h0, 1);
    checkOutput("lh_off1_load_data", load_data, 32'hFFFF_F001);
    applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 32'h0, 0);
    checkOutput("lhu_off2_load_data", load_data, 32'h0000_8001);
    clearObservations();
    applyStimulus(1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0, 32'h0, 0);
    checkOutput("sb_off1_wdata", seen_wdata[0], 32'h0000_A500);
    applyStimulus(1'b1, 3'b010, 32'h104, 32'h0102_0304, 32'h0, 32'h0, 3);
    applyStimulus(1'b0, 3'b011, 32'h108, 32'h0, 32'h1357_2468, 32'h0, 0);
    applyStimulus(1'b0, 3'b110, 32'h108, 32'h0, 32'h1357_2468, 32'h0, 2);
    checkOutput("code110_load_data", load_data, 32'h1357_2468);

    $display("[TB] misaligned LW 0x101");
    clearObservations();
    applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 32'h4433_2211, 32'h8877_6655, 1);
`ifdef MISALIGN_SPLIT_EN
    checkOutput("t4_txn_count", 32'(seen_addr.size()), 32'd2);
    checkOutput("t4_addr0", seen_addr[0], 32'h100);
    checkOutput("t4_be0", {28'd0, seen_be[0]}, 32'hE);
    checkOutput("t4_addr1", seen_addr[1], 32'h104);
    checkOutput("t4_be1", {28'd0, seen_be[1]}, 32'h1);
    checkOutput("t4_load_data", load_data, 32'h5544_3322);
`else
    checkOutput("t5_bus_valid_cycles", 32'(valid_cycles), 32'd0);
    checkOutput("t5_fault_done_cycles", 32'(fault_done_cycles), 32'd1);
    checkOutput("t5_stall_cycles", 32'(stall_cycles), 32'd1);
    checkOutput("t5_load_data_held", load_data, 32'h1357_2468);
`endif

    $display("[TB] other misaligned accesses");
    applyStimulus(1'b0, 3'b001, 32'h103, 32'h0, 32'hAB00_0000, 32'h0000_00CD, 0);
    applyStimulus(1'b1, 3'b010, 32'h102, 32'hCAFE_F00D, 32'h0, 32'h0, 1);
    applyStimulus(1'b0, 3'b101, 32'h103, 32'h0, 32'h9900_0000, 32'h0000_0088, 2);

    $display("[TB] reset during ACC0 wait");
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; byte_select = 3'b010; addr = 32'h200; wdata = 32'd0;
    bus.bus_ready = 1'b0;
    exp_stall = 1'b1; exp_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_stall = 1'b1; exp_valid = 1'b1;
    exp_addr = 32'h200; exp_be = 4'hF; exp_we = 1'b0; exp_wd = 32'd0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_bus_valid_in_reset", {31'd0, bus.bus_valid}, 32'd0);
    checkOutput("t6_stall_in_reset", {31'd0, stall}, 32'd0);
    checkOutput("t6_done_in_reset", {31'd0, done}, 32'd0);
    checkOutput("t6_load_data_in_reset", load_data, 32'd0);
    exp_stall = 1'b0; exp_valid = 1'b0; exp_ld = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clearObservations();
    applyStimulus(1'b0, 3'b010, 32'h200, 32'h0, 32'h0BEE_F00D, 32'h0, 1);
    checkOutput("t6_load_data", load_data, 32'h0BEE_F00D);
    checkOutput("t6_bus_addr", seen_addr[0], 32'h200);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
